// File: rtl/keyboard_input_buffer.sv
// keyboard_input_buffer: memory-mapped keyboard port for the eLC-3.
// Queues key codes in a DEPTH-entry FIFO and exposes KBSR/KBDR registers
// with a sticky overflow flag, an interrupt enable and an IRQ output.
module keyboard_input_buffer #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned DATA_W    = 8,
  parameter logic [15:0] KBSR_ADDR = 16'hFE00,
  parameter logic [15:0] KBDR_ADDR = 16'hFE02,
  parameter bit          DROP_ZERO = 1'b1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Keypress,
  input  logic [DATA_W-1:0]        ASCII,
  input  logic [15:0]              Address,
  input  logic                     MIO_EN,
  input  logic                     R_W,
  input  logic [15:0]              Data_In,
  output logic [15:0]              Data_Out,
  output logic                     Hit,
  output logic                     KBSR,
  output logic                     IRQ,
  output logic                     Overflow,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              ie;
  logic              prev_key;
  logic              rd_prev;

  logic              is_kbsr;
  logic              is_kbdr;
  logic              kbdr_rd;
  logic              kbsr_wr;
  logic              push_req;
  logic              empty;
  logic              full;
  logic              do_pop;
  logic              do_push;
  logic              ovf_set;
  logic [15:0]       head_ext;

  // Decode bus access and resolve push/pop/overflow for this cycle.
  // A pop is taken when a KBDR read ends, so the head stays stable for the
  // whole access; a same-cycle pop frees a slot before a push is judged full.
  always_comb begin
    is_kbsr  = (Address == KBSR_ADDR);
    is_kbdr  = (Address == KBDR_ADDR);
    kbdr_rd  = MIO_EN & ~R_W & is_kbdr;
    kbsr_wr  = MIO_EN & R_W & is_kbsr;
    push_req = Keypress & ~prev_key & ~(DROP_ZERO & (ASCII == '0));
    empty    = (Count == '0);
    full     = (Count == FULL_CNT);
    do_pop   = rd_prev & ~kbdr_rd & ~empty;
    do_push  = push_req & (~full | do_pop);
    ovf_set  = push_req & full & ~do_pop;
  end

  // Combinational read mux and status outputs.
  always_comb begin
    head_ext = '0;
    head_ext[DATA_W-1:0] = mem[rd_ptr];
    Hit      = MIO_EN & (is_kbsr | is_kbdr);
    KBSR     = ~empty;
    IRQ      = KBSR & ie;
    Data_Out = '0;
    if (Hit && is_kbsr) begin
      Data_Out = {KBSR, ie, Overflow, 13'b0};
    end else if (Hit && is_kbdr && !empty) begin
      Data_Out = head_ext;
    end
  end

  // FIFO storage; contents need no reset since Count gates every read.
  always_ff @(posedge Clk) begin
    if (do_push) begin
      mem[wr_ptr] <= ASCII;
    end
  end

  // Pointers, occupancy, control bits and edge-detect history.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      Count    <= '0;
      ie       <= 1'b0;
      Overflow <= 1'b0;
      prev_key <= 1'b1;
      rd_prev  <= 1'b0;
    end else begin
      prev_key <= Keypress;
      rd_prev  <= kbdr_rd;
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   Count <= Count + CNT_ONE;
        2'b01:   Count <= Count - CNT_ONE;
        default: Count <= Count;
      endcase
      if (kbsr_wr) begin
        ie <= Data_In[14];
      end
      // A dropped key in the same cycle as a write-1-to-clear keeps the flag set.
      if (ovf_set) begin
        Overflow <= 1'b1;
      end else if (kbsr_wr && Data_In[13]) begin
        Overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keyboard_input_buffer.sv
// Testbench for keyboard_input_buffer: directed stimulus, a list-based
// reference model per instance, and a per-cycle compare process.
module tb_keyboard_input_buffer;

  logic        Clk;
  logic        Reset;
  logic        Keypress;
  logic [7:0]  ASCII;
  logic [15:0] Address;
  logic        MIO_EN;
  logic        R_W;
  logic [15:0] Data_In;

  logic [15:0] d_data_out;
  logic        d_hit, d_kbsr, d_irq, d_ovf;
  logic [3:0]  d_count;
  logic [15:0] z_data_out;
  logic        z_hit, z_kbsr, z_irq, z_ovf;
  logic [3:0]  z_count;

  keyboard_input_buffer #(.DEPTH(8), .DATA_W(8), .KBSR_ADDR(16'hFE00),
                          .KBDR_ADDR(16'hFE02), .DROP_ZERO(1'b1)) dut (
    .Clk(Clk), .Reset(Reset), .Keypress(Keypress), .ASCII(ASCII),
    .Address(Address), .MIO_EN(MIO_EN), .R_W(R_W), .Data_In(Data_In),
    .Data_Out(d_data_out), .Hit(d_hit), .KBSR(d_kbsr), .IRQ(d_irq),
    .Overflow(d_ovf), .Count(d_count)
  );

  keyboard_input_buffer #(.DEPTH(8), .DATA_W(8), .KBSR_ADDR(16'hFE00),
                          .KBDR_ADDR(16'hFE02), .DROP_ZERO(1'b0)) dut_nz (
    .Clk(Clk), .Reset(Reset), .Keypress(Keypress), .ASCII(ASCII),
    .Address(Address), .MIO_EN(MIO_EN), .R_W(R_W), .Data_In(Data_In),
    .Data_Out(z_data_out), .Hit(z_hit), .KBSR(z_kbsr), .IRQ(z_irq),
    .Overflow(z_ovf), .Count(z_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: index 0 drops code 0, index 1 keeps it.
  // Each FIFO is a plain list, oldest key at position 0.
  logic [7:0] mq [2][8];
  int         msz [2];
  bit         mie [2];
  bit         movf [2];
  bit         mprev [2];
  bit         mrd [2];
  bit         rd_now, push, set_ovf;

  always @(posedge Clk) begin
    rd_now = MIO_EN && !R_W && (Address == 16'hFE02);
    for (int i = 0; i < 2; i++) begin
      if (Reset) begin
        msz[i] = 0; mie[i] = 0; movf[i] = 0; mprev[i] = 1; mrd[i] = 0;
      end else begin
        push    = Keypress && !mprev[i] && !(i == 0 && ASCII == 8'h00);
        set_ovf = 0;
        if (mrd[i] && !rd_now && msz[i] > 0) begin
          for (int k = 0; k < 7; k++) mq[i][k] = mq[i][k+1];
          msz[i] = msz[i] - 1;
        end
        if (push) begin
          if (msz[i] < 8) begin
            mq[i][msz[i]] = ASCII;
            msz[i] = msz[i] + 1;
          end else begin
            set_ovf = 1;
          end
        end
        if (MIO_EN && R_W && Address == 16'hFE00) begin
          mie[i] = Data_In[14];
          if (Data_In[13]) movf[i] = 0;
        end
        if (set_ovf) movf[i] = 1;
        mprev[i] = Keypress;
        mrd[i]   = rd_now;
      end
    end
  end

  function automatic logic [15:0] exp_data(input int i);
    logic hit;
    hit = MIO_EN && (Address == 16'hFE00 || Address == 16'hFE02);
    if (!hit) return 16'h0000;
    if (Address == 16'hFE00) return {msz[i] != 0, mie[i], movf[i], 13'b0};
    if (msz[i] == 0) return 16'h0000;
    return {8'h00, mq[i][0]};
  endfunction

  // Compare both instances against the model every cycle.
  always @(negedge Clk) begin
    if (check_en) begin
      chk("hit",       {15'b0, d_hit},  {15'b0, MIO_EN && (Address == 16'hFE00 || Address == 16'hFE02)});
      chk("data_out",  d_data_out,      exp_data(0));
      chk("kbsr",      {15'b0, d_kbsr}, {15'b0, msz[0] != 0});
      chk("irq",       {15'b0, d_irq},  {15'b0, (msz[0] != 0) && mie[0]});
      chk("overflow",  {15'b0, d_ovf},  {15'b0, movf[0]});
      chk("count",     {12'b0, d_count}, 16'(msz[0]));
      chk("nz_hit",    {15'b0, z_hit},  {15'b0, d_hit});
      chk("nz_data",   z_data_out,      exp_data(1));
      chk("nz_irq",    {15'b0, z_irq},  {15'b0, (msz[1] != 0) && mie[1]});
      chk("nz_ovf",    {15'b0, z_ovf},  {15'b0, movf[1]});
      chk("nz_count",  {12'b0, z_count}, 16'(msz[1]));
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    MIO_EN = 0; R_W = 0; Address = 16'h0000; Data_In = 16'h0000;
  endtask

  task automatic do_reset();
    Reset = 1; tick(); tick(); Reset = 0; tick();
  endtask

  task automatic key(input logic [7:0] code);
    ASCII = code; Keypress = 1; tick();
    Keypress = 0; tick();
  endtask

  task automatic read_kbdr(input int n, input logic [15:0] exp);
    Address = 16'hFE02; MIO_EN = 1; R_W = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge Clk);
      chk("kbdr_read", d_data_out, exp);
      tick();
    end
    idle();
    tick();
  endtask

  task automatic read_kbsr(input logic [15:0] exp);
    Address = 16'hFE00; MIO_EN = 1; R_W = 0;
    @(negedge Clk);
    chk("kbsr_read", d_data_out, exp);
    tick();
    idle();
  endtask

  task automatic write_reg(input logic [15:0] addr, input logic [15:0] val);
    Address = addr; MIO_EN = 1; R_W = 1; Data_In = val;
    tick();
    idle();
  endtask

  initial begin
    Reset = 1; Keypress = 0; ASCII = 8'h00; idle();
    tick();
    check_en = 1;
    do_reset();
    @(negedge Clk);
    chk("reset_count", {12'b0, d_count}, 16'h0000);
    chk("reset_kbsr",  {15'b0, d_kbsr},  16'h0000);

    // 1: three keys, three 2-cycle reads; a KBDR write changes nothing
    key(8'h41); key(8'h42); key(8'h43);
    write_reg(16'hFE02, 16'h1234);
    @(negedge Clk);
    chk("t1_count3", {12'b0, d_count}, 16'h0003);
    read_kbdr(2, 16'h0041);
    read_kbdr(2, 16'h0042);
    read_kbdr(2, 16'h0043);
    @(negedge Clk);
    chk("t1_count0", {12'b0, d_count}, 16'h0000);
    chk("t1_kbsr0",  {15'b0, d_kbsr},  16'h0000);

    // 2: overfill, then clear overflow
    do_reset();
    for (int k = 0; k < 9; k++) key(8'h61 + 8'(k));
    @(negedge Clk);
    chk("t2_count8", {12'b0, d_count}, 16'h0008);
    chk("t2_ovf",    {15'b0, d_ovf},   16'h0001);
    read_kbsr(16'hA000);
    write_reg(16'hFE00, 16'h2000);
    @(negedge Clk);
    chk("t2_ovf_clr", {15'b0, d_ovf}, 16'h0000);

    // 3: pop and push land on the same edge while full
    Address = 16'hFE02; MIO_EN = 1; R_W = 0;
    @(negedge Clk);
    chk("t3_head", d_data_out, 16'h0061);
    tick();
    idle(); ASCII = 8'h7A; Keypress = 1;
    tick();
    @(negedge Clk);
    chk("t3_count8", {12'b0, d_count}, 16'h0008);
    chk("t3_ovf0",   {15'b0, d_ovf},   16'h0000);
    Keypress = 0; tick();
    for (int k = 1; k < 8; k++) read_kbdr(1, 16'h0061 + 16'(k));
    read_kbdr(1, 16'h007A);
    @(negedge Clk);
    chk("t3_empty", {12'b0, d_count}, 16'h0000);

    // 4: held key, and key held through reset
    do_reset();
    ASCII = 8'h6B; Keypress = 1;
    repeat (20) tick();
    @(negedge Clk);
    chk("t4_held", {12'b0, d_count}, 16'h0001);
    do_reset();
    repeat (5) tick();
    @(negedge Clk);
    chk("t4_thru_reset", {12'b0, d_count}, 16'h0000);
    Keypress = 0; tick();

    // 5: zero code dropped only when DROP_ZERO is set
    key(8'h00);
    @(negedge Clk);
    chk("t5_drop",   {12'b0, d_count}, 16'h0000);
    chk("t5_nodrop", {12'b0, z_count}, 16'h0001);

    // 6: interrupt enable, IRQ timing, then wrap-around traffic
    do_reset();
    write_reg(16'hFE00, 16'h4000);
    ASCII = 8'h78; Keypress = 1;
    @(negedge Clk);
    chk("t6_irq_pre", {15'b0, d_irq}, 16'h0000);
    tick();
    @(negedge Clk);
    chk("t6_irq_on", {15'b0, d_irq}, 16'h0001);
    Keypress = 0; tick();
    read_kbdr(1, 16'h0078);
    @(negedge Clk);
    chk("t6_irq_off", {15'b0, d_irq}, 16'h0000);
    for (int k = 0; k < 10; k++) begin
      key(8'h30 + 8'(k));
      read_kbdr(1, 16'h0030 + 16'(k));
    end
    @(negedge Clk);
    chk("t6_final_count", {12'b0, d_count}, 16'h0000);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
